// File: rtl/f_pc_sequencer.sv
// Fetch-stage PC owner: sequences next fetch address, redirects, stalls,
// delay-slot flag, fetch address error and a sticky stall watchdog.
module f_pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC  = 32'h0000_4180,
    parameter logic [31:0] IM_BASE     = 32'h0000_3000,
    parameter logic [31:0] IM_LAST     = 32'h0000_6FFC,
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  D_nPCSel,
    input  logic [31:0] F_newPC,
    input  logic        Req,
    input  logic        eret,
    input  logic [31:0] EPC,
    output logic [31:0] F_PC,
    output logic        F_valid,
    output logic        F_BD,
    output logic        F_ExcAdEL,
    output logic        F_fetch_en,
    output logic        stall_timeout,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        HOLD  = 2'b10,
        REDIR = 2'b11
    } state_t;

    state_t      st_q, st_d;
    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        to_q, to_d;
    logic        redir;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q  <= BOOT;
            pc_q  <= RESET_PC;
            bd_q  <= 1'b0;
            cnt_q <= 8'd0;
            to_q  <= 1'b0;
        end else begin
            st_q  <= st_d;
            pc_q  <= pc_d;
            bd_q  <= bd_d;
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        pc_d  = pc_q;
        bd_d  = bd_q;
        redir = 1'b0;
        unique case (st_q)
            BOOT: begin
                if (Req) begin
                    pc_d  = HANDLER_PC;
                    bd_d  = 1'b0;
                    st_d  = REDIR;
                    redir = 1'b1;
                end else begin
                    st_d = RUN;
                end
            end
            default: begin
                if (Req) begin
                    pc_d  = HANDLER_PC;
                    bd_d  = 1'b0;
                    st_d  = REDIR;
                    redir = 1'b1;
                end else if (eret) begin
                    pc_d  = EPC;
                    bd_d  = 1'b0;
                    st_d  = REDIR;
                    redir = 1'b1;
                end else if (stall) begin
                    st_d = HOLD;
                end else begin
                    // Any non-ADD4 select, including undefined codes, marks a delay slot
                    pc_d = F_newPC;
                    bd_d = |D_nPCSel;
                    st_d = RUN;
                end
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (redir || !stall)
            cnt_d = 8'd0;
        else if (cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
        to_d = to_q | (cnt_d >= 8'(STALL_LIMIT));
    end

    logic bad_addr;
    assign bad_addr = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE)
                    || (pc_q > IM_LAST);

    assign F_PC          = pc_q;
    assign F_valid       = (st_q != BOOT);
    assign F_BD          = bd_q;
    assign F_ExcAdEL     = F_valid & bad_addr;
    assign F_fetch_en    = F_valid & ~F_ExcAdEL;
    assign stall_timeout = to_q;
    assign state         = st_q;

endmodule

// File: doc/f_pc_sequencer.md
Name: f_pc_sequencer

Overview:
- Owns the fetch-stage PC register. Sequences the next fetch address from the D-stage next-PC result, pipeline stalls, exception/interrupt entry and ERET return.
- Tracks the branch-delay-slot flag for the fetched instruction and flags fetch address errors (AdEL).
- Sits between the D-stage next-PC logic, the hazard unit and CP0. It is the only writer of F_PC.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LAST, 32'h0000_6FFC, highest legal fetch address (inclusive).
- STALL_LIMIT, 16, consecutive stall cycles before stall_timeout is set.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit: hold F and D.
- D_nPCSel  input  3  D-stage next-PC select (000 ADD4, 001 BEQ, 010 JAL, 011 JR, 100 BNE).
- F_newPC  input  32  next-PC value computed in D.
- Req  input  1  CP0 exception/interrupt request, flush and enter handler.
- eret  input  1  ERET is resolving: return to EPC.
- EPC  input  32  CP0 exception PC.
- F_PC  output  32  current fetch address.
- F_valid  output  1  F_PC holds a real fetch.
- F_BD  output  1  fetched instruction is in a branch delay slot.
- F_ExcAdEL  output  1  fetch address error for F_PC.
- F_fetch_en  output  1  F_valid & ~F_ExcAdEL (IM read enable).
- stall_timeout  output  1  sticky watchdog flag.
- state  output  2  FSM state, for debug.

Behaviour:
- Reset (reset=0, asynchronous):
  - F_PC=RESET_PC, state=BOOT, F_valid=0, F_BD=0, stall counter=0, stall_timeout=0.
  - Reset asserted mid-operation discards any pending redirect.
- FSM states: BOOT=00, RUN=01, HOLD=10, REDIR=11.
  - BOOT: lasts exactly one cycle after reset deasserts. F_valid=0, PC not advanced. Next state is RUN; if Req is high it is REDIR.
  - RUN: F_valid=1.
  - HOLD: entered on stall when there is no Req/eret. F_PC, F_BD held, F_valid=1. Exit to RUN when stall=0.
  - REDIR: the single cycle after a Req/eret redirect. F_valid=1, F_BD=0. Next is RUN, or HOLD if stall.
- Next-PC priority on each rising edge in RUN/HOLD/REDIR, highest first:
  1. Req: F_PC<=HANDLER_PC, F_BD<=0, state<=REDIR. Req overrides stall.
  2. eret: F_PC<=EPC, F_BD<=0, state<=REDIR. eret overrides stall; no delay slot executes after ERET.
  3. stall: hold everything, state<=HOLD.
  4. Otherwise: F_PC<=F_newPC, F_BD<=(D_nPCSel!=3'b000), state<=RUN.
- F_newPC arrives already muxed (taken branch/JAL/JR target, else F_PC+4). The sequencer does no target arithmetic and never adds 4 itself.
- Undefined D_nPCSel codes (101–111) are treated as non-ADD4 for the F_BD calculation.
- F_ExcAdEL is combinational on F_PC: it is 1 when F_PC[1:0]!=0, F_PC<IM_BASE or F_PC>IM_LAST (unsigned compares). It is valid in every state except BOOT, where it is 0.
- Stall watchdog:
  - An 8-bit counter increments each cycle with stall=1 and is cleared when stall=0 or on a Req/eret redirect. It saturates at 255.
  - stall_timeout is set when the counter reaches STALL_LIMIT and stays set until reset.
- Simultaneous Req and eret: Req wins and EPC is ignored.
- Redirect to a misaligned EPC: the redirect is taken and F_ExcAdEL asserts in the REDIR cycle.

Test Plan:
- Reset release, stall=0, F_newPC=F_PC+4: cycle 0 BOOT with F_PC=3000, F_valid=0. Then F_PC 3000 → 3004 → 3008, F_valid=1, F_BD=0.
- D_nPCSel=010 with F_newPC=0000_3100 at F_PC=3004: next F_PC=3100, F_BD=1. The following ADD4 cycle gives F_BD=0.
- stall=1 for 3 cycles at F_PC=3010: F_PC stays 3010, state=HOLD, F_valid=1. Resumes to F_newPC on release. stall=1 for 16 cycles sets stall_timeout, and it stays set.
- Req=1 together with stall=1 at F_PC=3020: next F_PC=4180, state=REDIR, F_BD=0. The next cycle is RUN.
- eret=1 with EPC=0000_3044: F_PC=3044, F_BD=0. Req and eret together with EPC=3044: F_PC=4180.
- EPC=0000_3046: F_ExcAdEL=1, F_fetch_en=0. F_newPC=0000_7000: F_ExcAdEL=1. F_PC=6FFC: F_ExcAdEL=0.
